// File: rtl/axil_bridge_pkg.sv
// Shared types for the APB/AXI4-Lite bridge.
//   state_t  : front-end FSM states
//   grant_t  : last arbitration winner (round-robin between read and write)
//   RESP_*   : AXI response encodings
//   offs_bits: number of byte-offset address bits for a given data width
package axil_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_WR_REQ  = 3'd2,
    ST_RD_RESP = 3'd3,
    ST_WR_RESP = 3'd4
  } state_t;

  typedef enum logic {
    GNT_READ  = 1'b0,
    GNT_WRITE = 1'b1
  } grant_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int offs_bits(input int dw);
    return (dw == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/axil_slave_frontend_if.sv
// Bus bundle between an AXI4-Lite master, the slave front end and the APB
// master stage's command port.
//   slave  modport: the front end's view (AXI slave, command requester)
//   master modport: the opposite side (AXI master, command completer)
interface axil_slave_frontend_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              wvalid, wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  logic              cmd_sel, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_prot;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;
  logic              cmd_ready, cmd_slverr;
  logic [DATA_W-1:0] cmd_rdata;

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready, cmd_ready, cmd_rdata, cmd_slverr,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
           cmd_sel, cmd_write, cmd_addr, cmd_prot, cmd_wdata, cmd_strb
  );

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready, cmd_ready, cmd_rdata, cmd_slverr,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
           cmd_sel, cmd_write, cmd_addr, cmd_prot, cmd_wdata, cmd_strb
  );

endinterface

// File: rtl/axil_wr_capture.sv
// AW/W capture: independent hold registers for the write address and write
// data channels. Either channel may complete first; wr_pend asserts once both
// are held. A held channel drops its ready and is never overwritten until
// i_clr (write completed) releases both.
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_en                channels may accept (front end idle and out of reset)
//   i_clr               release both holds
//   i_aw*/i_w*          AXI AW and W payload + valid
//   o_awready/o_wready  channel readies
//   o_wr_pend           both channels held
//   o_addr..o_strb      latched write payload
module axil_wr_capture #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_awvalid,
  input  logic [ADDR_W-1:0] i_awaddr,
  input  logic [2:0]        i_awprot,
  input  logic              i_wvalid,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  output logic              o_awready,
  output logic              o_wready,
  output logic              o_wr_pend,
  output logic [ADDR_W-1:0] o_addr,
  output logic [2:0]        o_prot,
  output logic [DATA_W-1:0] o_data,
  output logic [STRB_W-1:0] o_strb
);

  logic r_aw_hold, r_w_hold;

  assign o_awready = i_en & ~r_aw_hold;
  assign o_wready  = i_en & ~r_w_hold;
  assign o_wr_pend = r_aw_hold & r_w_hold;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_aw_hold <= 1'b0;
      r_w_hold  <= 1'b0;
      o_addr    <= '0;
      o_prot    <= '0;
      o_data    <= '0;
      o_strb    <= '0;
    end else if (i_clr) begin
      r_aw_hold <= 1'b0;
      r_w_hold  <= 1'b0;
    end else begin
      if (i_awvalid && o_awready) begin
        r_aw_hold <= 1'b1;
        o_addr    <= i_awaddr;
        o_prot    <= i_awprot;
      end
      if (i_wvalid && o_wready) begin
        r_w_hold <= 1'b1;
        o_data   <= i_wdata;
        o_strb   <= i_wstrb;
      end
    end
  end

endmodule

// File: rtl/axil_slave_frontend.sv
// AXI4-Lite slave front end of the APB/AXI4-Lite bridge. Serialises AXI
// reads and writes into single command requests for the APB master stage,
// one outstanding at a time, and returns the completion as a B or R response.
// Reads and fully-captured writes are granted round-robin.
// Ports:
//   clk, rst  clock, async active-high reset
//   bus       axil_slave_frontend_if.slave: AXI AW/W/B/AR/R channels and the
//             cmd_* request/completion port
// Optional: define AXIL_ALIGN_CHK_EN to answer misaligned addresses with
// SLVERR directly, without issuing a command.
module axil_slave_frontend
  import axil_bridge_pkg::*;
#(
  parameter int dataWidth = 32,
  parameter int addrWidth = 32
) (
  input logic                  clk,
  input logic                  rst,
  axil_slave_frontend_if.slave bus
);

  localparam int STRB_W = dataWidth / 8;

  state_t r_state, w_state_nxt;
  grant_t r_last_grant, w_grant_nxt;

  // Held low for the first cycle after reset so no ready is seen during reset.
  logic r_run;

  logic                 w_idle, w_arready, w_ar_hs, w_wr_pend, w_wr_blocks, w_wr_clr;
  logic                 w_ar_misalign, w_wr_misalign;
  logic [addrWidth-1:0] w_wr_addr;
  logic [2:0]           w_wr_prot;
  logic [dataWidth-1:0] w_wr_data;
  logic [STRB_W-1:0]    w_wr_strb;

  logic                 r_cmd_sel, r_cmd_write;
  logic [addrWidth-1:0] r_cmd_addr;
  logic [2:0]           r_cmd_prot;
  logic [dataWidth-1:0] r_cmd_wdata, r_rdata;
  logic [STRB_W-1:0]    r_cmd_strb;
  logic [1:0]           r_rresp, r_bresp;

  assign w_idle      = (r_state == ST_IDLE) & r_run;
  // A pending write that lost the last round blocks new reads.
  assign w_wr_blocks = w_wr_pend & (r_last_grant == GNT_READ);
  assign w_arready   = w_idle & ~w_wr_blocks;
  assign w_ar_hs     = bus.arvalid & w_arready;

`ifdef AXIL_ALIGN_CHK_EN
  localparam int OFFS_W = offs_bits(dataWidth);
  assign w_ar_misalign = |bus.araddr[OFFS_W-1:0];
  assign w_wr_misalign = |w_wr_addr[OFFS_W-1:0];
`else
  assign w_ar_misalign = 1'b0;
  assign w_wr_misalign = 1'b0;
`endif

  axil_wr_capture #(.DATA_W(dataWidth), .ADDR_W(addrWidth)) u_wr_capture (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (w_idle),
    .i_clr     (w_wr_clr),
    .i_awvalid (bus.awvalid),
    .i_awaddr  (bus.awaddr),
    .i_awprot  (bus.awprot),
    .i_wvalid  (bus.wvalid),
    .i_wdata   (bus.wdata),
    .i_wstrb   (bus.wstrb),
    .o_awready (bus.awready),
    .o_wready  (bus.wready),
    .o_wr_pend (w_wr_pend),
    .o_addr    (w_wr_addr),
    .o_prot    (w_wr_prot),
    .o_data    (w_wr_data),
    .o_strb    (w_wr_strb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GNT_WRITE;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_last_grant;
    w_wr_clr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ar_hs) begin
          w_grant_nxt = GNT_READ;
          w_state_nxt = w_ar_misalign ? ST_RD_RESP : ST_RD_REQ;
        end else if (w_wr_pend) begin
          w_grant_nxt = GNT_WRITE;
          if (w_wr_misalign) begin
            w_state_nxt = ST_WR_RESP;
            w_wr_clr    = 1'b1;
          end else begin
            w_state_nxt = ST_WR_REQ;
          end
        end
      end
      ST_RD_REQ:  if (bus.cmd_ready) w_state_nxt = ST_RD_RESP;
      ST_WR_REQ: begin
        if (bus.cmd_ready) begin
          w_state_nxt = ST_WR_RESP;
          w_wr_clr    = 1'b1;
        end
      end
      ST_RD_RESP: if (bus.rready) w_state_nxt = ST_IDLE;
      ST_WR_RESP: if (bus.bready) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Command and response registers; cmd fields load once at grant and hold
  // for the whole request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run       <= 1'b0;
      r_cmd_sel   <= 1'b0;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_prot  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_strb  <= '0;
      r_rdata     <= '0;
      r_rresp     <= RESP_OKAY;
      r_bresp     <= RESP_OKAY;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_ar_hs) begin
            if (w_ar_misalign) begin
              r_rdata <= '0;
              r_rresp <= RESP_SLVERR;
            end else begin
              r_cmd_sel   <= 1'b1;
              r_cmd_write <= 1'b0;
              r_cmd_addr  <= bus.araddr;
              r_cmd_prot  <= bus.arprot;
              r_cmd_wdata <= '0;
              r_cmd_strb  <= '0;
            end
          end else if (w_wr_pend) begin
            if (w_wr_misalign) begin
              r_bresp <= RESP_SLVERR;
            end else begin
              r_cmd_sel   <= 1'b1;
              r_cmd_write <= 1'b1;
              r_cmd_addr  <= w_wr_addr;
              r_cmd_prot  <= w_wr_prot;
              r_cmd_wdata <= w_wr_data;
              r_cmd_strb  <= w_wr_strb;
            end
          end
        end
        ST_RD_REQ: begin
          if (bus.cmd_ready) begin
            r_cmd_sel <= 1'b0;
            r_rdata   <= bus.cmd_rdata;
            r_rresp   <= bus.cmd_slverr ? RESP_SLVERR : RESP_OKAY;
          end
        end
        ST_WR_REQ: begin
          if (bus.cmd_ready) begin
            r_cmd_sel <= 1'b0;
            r_bresp   <= bus.cmd_slverr ? RESP_SLVERR : RESP_OKAY;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.arready   = w_arready;
  assign bus.rvalid    = (r_state == ST_RD_RESP);
  assign bus.bvalid    = (r_state == ST_WR_RESP);
  assign bus.rdata     = r_rdata;
  assign bus.rresp     = r_rresp;
  assign bus.bresp     = r_bresp;
  assign bus.cmd_sel   = r_cmd_sel;
  assign bus.cmd_write = r_cmd_write;
  assign bus.cmd_addr  = r_cmd_addr;
  assign bus.cmd_prot  = r_cmd_prot;
  assign bus.cmd_wdata = r_cmd_wdata;
  assign bus.cmd_strb  = r_cmd_strb;

endmodule

// File: doc/axil_slave_frontend.md
Name: axil_slave_frontend

Overview:
- AXI4-Lite slave front end of the APB/AXI4-Lite bridge, directly upstream of the APB master stage.
- Accepts AXI4-Lite read/write transactions and serialises them into single command requests. Each request carries select, write, address, write data, strobe and prot, and is handed to the APB master stage.
- Returns the completion (ready, read data, slave error) to the AXI master as a B or R response.
- Exactly one transaction is outstanding at any time.

Parameters:
- dataWidth, 32, AXI and command data width; 32 or 64 only.
- addrWidth, 32, AXI and command address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- awvalid  in  1  / awready  out  1 / awaddr  in  addrWidth / awprot  in  3: AXI write address channel.
- wvalid  in  1  / wready  out  1 / wdata  in  dataWidth / wstrb  in  dataWidth/8: AXI write data channel.
- bvalid  out  1 / bready  in  1 / bresp  out  2: AXI write response channel.
- arvalid  in  1 / arready  out  1 / araddr  in  addrWidth / arprot  in  3: AXI read address channel.
- rvalid  out  1 / rready  in  1 / rdata  out  dataWidth / rresp  out  2: AXI read data channel.
- cmd_sel  out  1: request to the APB master; held high until completion.
- cmd_write  out  1 / cmd_addr  out  addrWidth / cmd_prot  out  3 / cmd_wdata  out  dataWidth / cmd_strb  out  dataWidth/8: request fields.
- cmd_ready  in  1: completion from the APB master, sampled only while cmd_sel is high.
- cmd_rdata  in  dataWidth / cmd_slverr  in  1: completion data and error.

Behaviour:
- Reset:
  - All outputs go to 0: all ready and valid signals, cmd_sel, every cmd field, bresp, rresp, rdata.
  - Hold flags clear, last_grant = WRITE, state = IDLE.
  - Reset mid-transaction abandons it; no response is issued after reset.
- State machine: IDLE, RD_REQ, WR_REQ, RD_RESP, WR_RESP.
- Write capture:
  - awready = IDLE & ~aw_hold; wready = IDLE & ~w_hold.
  - Each handshake latches its payload and sets its hold flag. AW and W may arrive in either order or together.
  - wr_pend = aw_hold & w_hold.
- Read capture: arready = IDLE & ~wr_pend_blocks. wr_pend_blocks = wr_pend & (last_grant == READ).
- Arbitration in IDLE:
  - An AR handshake goes to RD_REQ and sets last_grant = READ.
  - Otherwise, wr_pend goes to WR_REQ and sets last_grant = WRITE.
  - When AR and a full write are both pending, grants alternate (round-robin).
- Latency:
  - cmd_sel rises the cycle after the AR handshake.
  - For writes, cmd_sel rises the cycle after wr_pend is first seen in IDLE.
- RD_REQ / WR_REQ:
  - cmd_sel = 1; cmd fields are constant for the whole request; cmd_wdata and cmd_strb = 0 on reads.
  - When cmd_ready = 1, the next state is RD_RESP or WR_RESP and cmd_sel drops on that edge.
  - rdata captures cmd_rdata; resp = cmd_slverr ? 2'b10 (SLVERR) : 2'b00 (OKAY).
  - A write completion clears both hold flags.
- RD_RESP: rvalid = 1; rdata and rresp are stable until rready; on the handshake, go to IDLE.
- WR_RESP: bvalid = 1; bresp is stable until bready; on the handshake, go to IDLE.
- Backpressure: while in a response state, all AXI ready signals are 0, including AW/W for a not-yet-held channel. A held channel is not overwritten.
- cmd_ready while cmd_sel = 0 is ignored.
- Address width: no truncation; cmd_addr is the full captured address.

Optional Feature:
- Macro: AXIL_ALIGN_CHK_EN.
- Defined:
  - A captured address with a nonzero byte offset (low log2(dataWidth/8) bits) skips the REQ state.
  - The block goes directly to RESP with SLVERR, rdata = 0, and no cmd_sel pulse.
- Undefined: addresses pass unchecked and the low bits are forwarded unchanged.

Decomposition:
- Shared package axil_bridge_pkg holds:
  - the state enum type;
  - resp constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - the grant enum (READ/WRITE).
- One sub-module, axil_wr_capture: the AW/W hold registers and flags, producing wr_pend and the latched payload. Arbitration and the FSM stay in the top module.

Test Plan:
- Write, AW and W in the same cycle:
  - Stimulus: awaddr = 0x10, wdata = 0xDEADBEEF, wstrb = 0xF; cmd_ready two cycles after cmd_sel.
  - Required: cmd_write = 1 with those values; bvalid with bresp = 00; cmd_sel drops on the completion edge.
- W three cycles before AW:
  - Required: wready low after the W handshake; no cmd_sel until AW arrives; then a single request with the correct address/data.
- Read with an error:
  - Stimulus: araddr = 0x24; cmd_rdata = 0x12345678, cmd_slverr = 1.
  - Required: rvalid with rdata = 0x12345678, rresp = 10; with rready held low for 4 cycles, rdata and rresp stay stable.
- AR and a full write both pending from reset:
  - Required: the first grant is the read (last_grant reset = WRITE), then the write, then the read again when both stay pending.
- Reset asserted mid-WR_REQ (cmd_sel = 1):
  - Required: cmd_sel and bvalid are 0 immediately (asynchronously); hold flags cleared; the next write works normally.
- With AXIL_ALIGN_CHK_EN defined:
  - Stimulus: araddr = 0x13.
  - Required: rresp = 10, rdata = 0, cmd_sel never asserted.
